cb_dequantizer: RTL and testbench
=================================

CB_DEQUANTIZER -- requirements
Module: cb_dequantizer

Interface
REQ-001 SHALL expose clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL expose rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL expose enable  input  1  block-valid; a block is accepted when enable=1 and ready=1 on the same edge.
REQ-004 SHALL expose ready  output  1  high only in IDLE.
REQ-005 SHALL expose Q  input  signed 11 x [0:7][0:7]  quantized Cb coefficients, sampled only on acceptance.
REQ-006 SHALL expose Z  output  signed 11 x [0:7][0:7]  dequantized Cb DCT coefficients.
REQ-007 SHALL expose out_enable  output  1  one-cycle pulse marking Z as newly valid.
REQ-008 SHALL take its divisor table from Q_MATRIX in package QUANTIZER_constants (entries 1..255, unsigned); no other parameters.

Function
REQ-009 SHALL implement FSM states IDLE, ROW, DONE.
REQ-010 IDLE: ready=1; on enable=1, SHALL register all 64 Q values into an internal block buffer, clear 3-bit row counter r to 0, go to ROW.
REQ-011 ROW: each cycle SHALL compute the 8 products Qbuf[r][j] * Q_MATRIX[r][j] (11b signed x 8b unsigned -> 19b signed), saturate, and write into working buffer row r.
REQ-012 Saturation SHALL clamp to [-1024, +1023]; in-range products pass unchanged; no rounding (exact integer product).
REQ-013 ROW SHALL increment r each cycle; when r=7 is processed SHALL go to DONE (r wraps to 0, not reused).
REQ-014 DONE: SHALL copy the working buffer to Z, assert out_enable for exactly that cycle, return to IDLE.
REQ-015 Latency SHALL be fixed: acceptance on edge N -> Z updated and out_enable=1 in the cycle following edge N+9; throughput one block per 10 cycles.
REQ-016 enable while ready=0 SHALL be ignored (no queuing); Q changes while busy SHALL not affect the block in flight.
REQ-017 enable asserted in the DONE cycle SHALL be ignored; acceptance resumes in the next IDLE cycle.
REQ-018 Z SHALL hold its last value between out_enable pulses; Z changes only in DONE.
REQ-019 out_enable SHALL never be high for two consecutive cycles.
REQ-020 ready SHALL be a registered/state-decoded signal with no combinational path from enable or Q.

Reset
REQ-021 On rst=1 at a clock edge SHALL enter IDLE, r=0, ready=1, out_enable=0, Z all 0, internal buffers all 0.
REQ-022 rst SHALL take priority over enable and over any in-flight block; an aborted block SHALL produce no out_enable.
REQ-023 First acceptance SHALL be possible on the first edge with rst=0.

Verification
REQ-024 All-zero block accepted after reset -> out_enable exactly 10 cycles after acceptance, Z all 0, ready low for cycles 1..9.
REQ-025 Q[i][j]=1 for all i,j -> Z[i][j]=Q_MATRIX[i][j]; Q[i][j]=-3 -> Z[i][j]=-3*Q_MATRIX[i][j] (clamped per REQ-012).
REQ-026 Saturation: Q[0][0]=1023, Q[7][7]=-1024 with Q_MATRIX entries >=2 -> Z[0][0]=1023, Z[7][7]=-1024; entries equal to 1 pass 1023/-1024 unchanged.
REQ-027 Back-to-back: enable held high continuously with changing Q -> blocks accepted every 10 cycles, each Z matches the Q sampled at its own acceptance edge.
REQ-028 Reset mid-block: rst pulsed 4 cycles after acceptance -> no out_enable, Z=0, ready=1 next cycle; new block then completes with correct values.
REQ-029 Round-trip: random Cb block through cb_quantizer then cb_dequantizer -> |Z - original| <= Q_MATRIX[i][j]/2 + 1 per coefficient, barring saturation.

Source files
------------

// File: rtl/cb_dequantizer.sv
// Cb block dequantizer: scales an 8x8 block of quantized coefficients by the
// chroma divisor table, one row per cycle, and saturates each result to 11 bits.
package QUANTIZER_constants;
    localparam logic [7:0] Q_MATRIX [0:7][0:7] = '{
        '{8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99},
        '{8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99},
        '{8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99},
        '{8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99},
        '{8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99},
        '{8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99},
        '{8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99},
        '{8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99}
    };
endpackage

// One column lane: signed coefficient times unsigned divisor, clamped to 11 bits.
module cb_deq_lane (
    input  logic signed [10:0] q,
    input  logic        [7:0]  m,
    output logic signed [10:0] z
);
    logic signed [19:0] prod;

    always_comb begin
        // |q*m| <= 1024*255, so 20 signed bits hold the exact product
        prod = $signed({{9{q[10]}}, q}) * $signed({12'd0, m});
        if (prod > 20'sd1023)
            z = 11'sh3FF;
        else if (prod < -20'sd1024)
            z = 11'sh400;
        else
            z = prod[10:0];
    end
endmodule

module cb_dequantizer
    import QUANTIZER_constants::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               ready,
    input  logic signed [10:0] Q [0:7][0:7],
    output logic signed [10:0] Z [0:7][0:7],
    output logic               out_enable
);
    typedef enum logic [1:0] {IDLE, ROW, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         r;
    logic signed [10:0] qbuf  [0:7][0:7];
    logic signed [10:0] work  [0:7][0:7];
    logic signed [10:0] row_z [0:7];

    assign ready = (state_q == IDLE);

    for (genvar j = 0; j < 8; j++) begin : g_lane
        cb_deq_lane u_lane (
            .q (qbuf[r][j]),
            .m (Q_MATRIX[r][j]),
            .z (row_z[j])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = ROW;
            ROW:     if (r == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            r          <= 3'd0;
            out_enable <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    qbuf[i][j] <= '0;
                    work[i][j] <= '0;
                    Z[i][j]    <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            out_enable <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        qbuf <= Q;
                        r    <= 3'd0;
                    end
                end
                ROW: begin
                    for (int j = 0; j < 8; j++) work[r][j] <= row_z[j];
                    r <= r + 3'd1;
                end
                DONE: Z <= work;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cb_dequantizer.sv
// Directed bench for cb_dequantizer: table of block patterns plus back-to-back,
// mid-block reset, output hold and quantize/dequantize round-trip sequences.
module tb_cb_dequantizer;
    import QUANTIZER_constants::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               ready;
    logic               out_enable;
    logic signed [10:0] Q [0:7][0:7];
    logic signed [10:0] Z [0:7][0:7];

    int total = 0;
    int bad   = 0;
    int exp_z [0:7][0:7];
    int orig  [0:7][0:7];
    int qv    [0:7][0:7];

    typedef struct {
        int f;
        int q00;
        int q77;
        int e00;
        int e77;
        int e34;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    cb_dequantizer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ready      (ready),
        .Q          (Q),
        .Z          (Z),
        .out_enable (out_enable)
    );

    function automatic int deq(int q, int m);
        int p;
        p = q * m;
        if (p > 1023) return 1023;
        if (p < -1024) return -1024;
        return p;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_q(int f, int q00, int q77);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                Q[i][j] = 11'(f);
        Q[0][0] = 11'(q00);
        Q[7][7] = 11'(q77);
    endtask

    task automatic calc_exp();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                exp_z[i][j] = deq(int'(Q[i][j]), int'(Q_MATRIX[i][j]));
    endtask

    task automatic z_match(string name);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (int'(Z[i][j]) != exp_z[i][j]) n++;
        check({name, " z_mismatches"}, n, 0);
    endtask

    task automatic z_zero(string name);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (Z[i][j] != 11'sd0) n++;
        check({name, " z_nonzero"}, n, 0);
    endtask

    // Called at a negedge with ready expected high; returns cycles to out_enable.
    task automatic run_block(string name);
        int rhigh;
        int lat;
        rhigh = 0;
        lat   = -1;
        enable = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) enable = 1'b0;
            if (k <= 9 && ready) rhigh++;
            if (out_enable) begin
                lat = k;
                break;
            end
        end
        check({name, " ready_high_while_busy"}, rhigh, 0);
        check({name, " latency"}, lat, 10);
    endtask

    initial begin
        tbl[0] = '{0,   0,    0,     0,     0,     0};
        tbl[1] = '{1,   1,    1,     17,    99,    99};
        tbl[2] = '{-3,  -3,   -3,    -51,   -297,  -297};
        tbl[3] = '{5,   1023, -1024, 1023,  -1024, 495};
        tbl[4] = '{11,  11,   11,    187,   1023,  1023};
        tbl[5] = '{-10, -10,  -10,   -170,  -990,  -990};
        tbl[6] = '{-11, -11,  -11,   -187,  -1024, -1024};
        tbl[7] = '{60,  60,   60,    1020,  1023,  1023};
        tbl[8] = '{-61, -61,  -61,   -1024, -1024, -1024};

        rst    = 1'b1;
        enable = 1'b1;
        fill_q(9, 9, 9);
        @(negedge clk);
        @(negedge clk);
        check("reset ready", int'(ready), 1);
        check("reset out_enable", int'(out_enable), 0);
        z_zero("reset");
        rst = 1'b0;

        // first vector is accepted on the first edge after reset release
        for (int v = 0; v < 9; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            fill_q(tbl[v].f, tbl[v].q00, tbl[v].q77);
            calc_exp();
            run_block(nm);
            z_match(nm);
            check({nm, " z00"}, int'(Z[0][0]), tbl[v].e00);
            check({nm, " z77"}, int'(Z[7][7]), tbl[v].e77);
            check({nm, " z34"}, int'(Z[3][4]), tbl[v].e34);
            @(negedge clk);
            check({nm, " oe_single"}, int'(out_enable), 0);
            check({nm, " ready_after"}, int'(ready), 1);
        end

        // back-to-back with enable held high; Q moves on while each block is busy
        begin
            int fs [4];
            fs = '{2, -4, 9, 77};
            fill_q(fs[0], fs[0], fs[0]);
            calc_exp();
            enable = 1'b1;
            for (int b = 0; b < 3; b++) begin
                int lat;
                string nm;
                nm = $sformatf("b2b%0d", b);
                @(posedge clk);
                @(negedge clk);
                fill_q(fs[b+1], fs[b+1], -fs[b+1]);
                lat = -1;
                for (int k = 1; k <= 20; k++) begin
                    if (k > 1) @(negedge clk);
                    if (out_enable) begin
                        lat = k;
                        break;
                    end
                end
                check({nm, " latency"}, lat, 10);
                z_match(nm);
                calc_exp();
            end
            enable = 1'b0;
        end

        // reset four cycles into a block: no output, then a clean block
        begin
            int oe;
            fill_q(7, 7, 7);
            enable = 1'b1;
            @(posedge clk);
            @(negedge clk);
            enable = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midrst ready", int'(ready), 1);
            check("midrst out_enable", int'(out_enable), 0);
            z_zero("midrst");
            oe = 0;
            repeat (15) begin
                @(negedge clk);
                if (out_enable) oe++;
            end
            check("midrst aborted_oe", oe, 0);
            fill_q(-2, 3, -5);
            calc_exp();
            run_block("postrst");
            z_match("postrst");
        end

        // Z holds while idle even though Q keeps changing
        begin
            int oe;
            oe = 0;
            fill_q(50, -50, 50);
            repeat (12) begin
                @(negedge clk);
                if (out_enable) oe++;
            end
            check("hold oe", oe, 0);
            z_match("hold");
        end

        // round trip: bench-side rounding quantizer, then the DUT
        for (int t = 0; t < 3; t++) begin
            int err;
            string nm;
            nm = $sformatf("rt%0d", t);
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    int m;
                    m = int'(Q_MATRIX[i][j]);
                    orig[i][j] = int'($urandom_range(1800, 0)) - 900;
                    if (orig[i][j] >= 0) qv[i][j] = (orig[i][j] + m / 2) / m;
                    else                 qv[i][j] = -((-orig[i][j] + m / 2) / m);
                    Q[i][j] = 11'(qv[i][j]);
                end
            end
            run_block(nm);
            err = 0;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    int m, p, d;
                    m = int'(Q_MATRIX[i][j]);
                    p = qv[i][j] * m;
                    d = int'(Z[i][j]) - orig[i][j];
                    if (d < 0) d = -d;
                    if (p <= 1023 && p >= -1024 && d > m / 2 + 1) err++;
                end
            end
            check({nm, " roundtrip_err"}, err, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
